// File: rtl/meta_write_scheduler.sv
// Round-robin scheduler for tag-array metadata writes: N requesters feed a small
// in-order FIFO that drains when the read port is idle, with a starvation override.
//
// state  | meaning
// IDLE   | writes drain only on cycles with no tag-array read; starve counter runs
// FORCE  | readers held off via io_rd_block until exactly one queued write retires
module meta_write_scheduler #(
    parameter int N_REQ        = 8,
    parameter int IDX_W        = 6,
    parameter int WAY_W        = 8,
    parameter int TAG_W        = 20,
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         io_in_valid,
    output logic [N_REQ-1:0]         io_in_ready,
    input  logic [N_REQ*IDX_W-1:0]   io_in_idx,
    input  logic [N_REQ*WAY_W-1:0]   io_in_way_en,
    input  logic [N_REQ*TAG_W-1:0]   io_in_tag,
    input  logic                     io_rd_busy,
    output logic                     io_rd_block,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [IDX_W-1:0]         io_out_idx,
    output logic [WAY_W-1:0]         io_out_way_en,
    output logic [TAG_W-1:0]         io_out_tag,
    output logic                     io_starved
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_FORCE = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            starved_q, starved_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   head_q, head_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IDX_W-1:0] mem_idx_q [QDEPTH];
    logic [IDX_W-1:0] mem_idx_d [QDEPTH];
    logic [WAY_W-1:0] mem_way_q [QDEPTH];
    logic [WAY_W-1:0] mem_way_d [QDEPTH];
    logic [TAG_W-1:0] mem_tag_q [QDEPTH];
    logic [TAG_W-1:0] mem_tag_d [QDEPTH];

    logic            gnt_any;
    logic [GW-1:0]   gnt_idx;
    logic            can_enq;
    logic            enq_fire;
    logic            deq_fire;
    logic            starve_inc;
    logic [PW-1:0]   tail;

    // Scan from the farthest candidate back so the last hit is the nearest one after rr_q.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (io_in_valid[(int'(rr_q) + k) % N_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = GW'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    assign io_out_valid = (count_q != '0) & (~io_rd_busy | (state_q == ST_FORCE));
    assign deq_fire     = io_out_valid & io_out_ready;
    assign can_enq      = (count_q < CW'(QDEPTH)) | deq_fire;
    assign enq_fire     = gnt_any & can_enq & ~reset;
    assign io_in_ready  = enq_fire ? (N_REQ'(1) << gnt_idx) : '0;
    assign starve_inc   = (count_q != '0) & io_rd_busy & ~deq_fire;
    assign tail         = PW'((int'(head_q) + int'(count_q)) % QDEPTH);

    assign io_out_idx    = mem_idx_q[head_q];
    assign io_out_way_en = mem_way_q[head_q];
    assign io_out_tag    = mem_tag_q[head_q];

    // When full with a dequeue, tail aliases head: the retiring slot takes the new entry.
    always_comb begin
        mem_idx_d = mem_idx_q;
        mem_way_d = mem_way_q;
        mem_tag_d = mem_tag_q;
        if (enq_fire) begin
            mem_idx_d[tail] = io_in_idx[int'(gnt_idx)*IDX_W +: IDX_W];
            mem_way_d[tail] = io_in_way_en[int'(gnt_idx)*WAY_W +: WAY_W];
            mem_tag_d[tail] = io_in_tag[int'(gnt_idx)*TAG_W +: TAG_W];
        end
    end

    always_comb begin
        rr_d    = enq_fire ? gnt_idx : rr_q;
        head_d  = head_q;
        if (deq_fire) begin
            head_d = (head_q == PW'(QDEPTH - 1)) ? '0 : head_q + PW'(1);
        end
        count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q    <= GW'(N_REQ - 1);
            head_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_idx_q[i] <= '0;
                mem_way_q[i] <= '0;
                mem_tag_q[i] <= '0;
            end
        end else begin
            rr_q      <= rr_d;
            head_q    <= head_d;
            count_q   <= count_d;
            mem_idx_q <= mem_idx_d;
            mem_way_q <= mem_way_d;
            mem_tag_q <= mem_tag_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            starved_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            starved_q    <= starved_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        starved_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (starve_inc) begin
                    if (starve_cnt_q == SW'(STARVE_LIMIT - 1)) begin
                        state_d      = ST_FORCE;
                        starve_cnt_d = '0;
                        starved_d    = 1'b1;
                    end else begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end
            ST_FORCE: begin
                starve_cnt_d = '0;
                if (deq_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        io_rd_block = (state_q == ST_FORCE);
        io_starved  = starved_q;
    end

endmodule

// File: tb/tb_meta_write_scheduler.sv
// Bench for meta_write_scheduler: fixed vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_meta_write_scheduler;

    localparam int N  = 8;
    localparam int IW = 6;
    localparam int WW = 8;
    localparam int TW = 20;
    localparam int QD = 2;
    localparam int SL = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     io_in_valid;
    logic [N-1:0]     io_in_ready;
    logic [N*IW-1:0]  io_in_idx;
    logic [N*WW-1:0]  io_in_way_en;
    logic [N*TW-1:0]  io_in_tag;
    logic             io_rd_busy;
    logic             io_rd_block;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [IW-1:0]    io_out_idx;
    logic [WW-1:0]    io_out_way_en;
    logic [TW-1:0]    io_out_tag;
    logic             io_starved;

    meta_write_scheduler #(
        .N_REQ(N), .IDX_W(IW), .WAY_W(WW), .TAG_W(TW), .QDEPTH(QD), .STARVE_LIMIT(SL)
    ) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_idx(io_in_idx), .io_in_way_en(io_in_way_en), .io_in_tag(io_in_tag),
        .io_rd_busy(io_rd_busy), .io_rd_block(io_rd_block),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_idx(io_out_idx), .io_out_way_en(io_out_way_en), .io_out_tag(io_out_tag),
        .io_starved(io_starved)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of entries plus rotating pointer and starvation bookkeeping.
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [WW-1:0] way;
        logic [TW-1:0] tag;
    } ent_t;

    ent_t q[$];
    int   m_rr;
    int   m_cnt;
    bit   m_force;
    bit   m_starved;

    logic [N-1:0] e_ready;
    bit   e_ovalid, e_deq, e_enq;
    int   e_g;
    int   n_cnt;
    bit   n_force, n_starved;

    task automatic model_reset();
        q.delete();
        m_rr      = N - 1;
        m_cnt     = 0;
        m_force   = 0;
        m_starved = 0;
    endtask

    task automatic model_eval();
        bit can;
        e_g = -1;
        for (int k = 1; k <= N; k++) begin
            if (e_g < 0 && io_in_valid[(m_rr + k) % N]) e_g = (m_rr + k) % N;
        end
        e_ovalid = (q.size() != 0) && (!io_rd_busy || m_force);
        e_deq    = e_ovalid && io_out_ready;
        can      = (q.size() < QD) || e_deq;
        e_enq    = (e_g >= 0) && can;
        e_ready  = '0;
        if (e_enq) e_ready[e_g] = 1'b1;
        n_force   = m_force;
        n_cnt     = m_cnt;
        n_starved = 0;
        if (!m_force) begin
            if (q.size() != 0 && io_rd_busy && !e_deq) begin
                if (m_cnt == SL - 1) begin
                    n_force   = 1;
                    n_cnt     = 0;
                    n_starved = 1;
                end else begin
                    n_cnt = m_cnt + 1;
                end
            end else begin
                n_cnt = 0;
            end
        end else if (e_deq) begin
            n_force = 0;
        end
    endtask

    task automatic model_compare();
        chk("in_ready", 64'(io_in_ready), 64'(e_ready));
        chk("out_valid", 64'(io_out_valid), 64'(e_ovalid));
        chk("rd_block", 64'(io_rd_block), 64'(m_force));
        chk("starved", 64'(io_starved), 64'(m_starved));
        if (e_ovalid) begin
            chk("out_head", 64'({io_out_idx, io_out_way_en, io_out_tag}), 64'(q[0]));
        end
    endtask

    task automatic drive_eval(input logic [N-1:0] v, input logic busy, input logic ordy);
        io_in_valid  = v;
        io_rd_busy   = busy;
        io_out_ready = ordy;
        #4;
        model_eval();
    endtask

    task automatic advance();
        ent_t e;
        @(posedge clock);
        if (e_deq) void'(q.pop_front());
        if (e_enq) begin
            e.idx = io_in_idx[e_g*IW +: IW];
            e.way = io_in_way_en[e_g*WW +: WW];
            e.tag = io_in_tag[e_g*TW +: TW];
            q.push_back(e);
            m_rr = e_g;
        end
        m_force   = n_force;
        m_cnt     = n_cnt;
        m_starved = n_starved;
        #1;
    endtask

    task automatic set_fixed_data();
        for (int i = 0; i < N; i++) begin
            io_in_idx[i*IW +: IW]    = IW'(i*5 + 3);
            io_in_way_en[i*WW +: WW] = WW'(1) << i;
            io_in_tag[i*TW +: TW]    = TW'(32'hA0000 + i);
        end
    endtask

    task automatic set_rand_data();
        for (int i = 0; i < N; i++) begin
            io_in_idx[i*IW +: IW]    = IW'($urandom);
            io_in_way_en[i*WW +: WW] = WW'($urandom);
            io_in_tag[i*TW +: TW]    = TW'($urandom);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_in_valid = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0]  v;
        logic          busy;
        logic          ordy;
        logic [N-1:0]  x_ready;
        logic          x_ovalid;
        logic          x_block;
        logic [IW-1:0] x_idx;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{8'h24, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 6'd0};
        tbl[1]  = '{8'h24, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 6'd13};
        tbl[2]  = '{8'h24, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 6'd28};
        tbl[3]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd13};
        tbl[4]  = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 6'd13};
        tbl[5]  = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd13};
        tbl[6]  = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 6'd13};
        tbl[7]  = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd3};
        tbl[8]  = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 6'd3};
        tbl[9]  = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 6'd3};
        tbl[10] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 6'd3};

        reset        = 1'b1;
        io_in_valid  = '1;
        io_rd_busy   = 1'b0;
        io_out_ready = 1'b1;
        set_fixed_data();
        model_reset();
        #3;
        chk("reset_in_ready", 64'(io_in_ready), 64'(0));
        chk("reset_out_valid", 64'(io_out_valid), 64'(0));
        chk("reset_rd_block", 64'(io_rd_block), 64'(0));
        chk("reset_starved", 64'(io_starved), 64'(0));
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive_eval(tbl[i].v, tbl[i].busy, tbl[i].ordy);
            chk("tbl_in_ready", 64'(io_in_ready), 64'(tbl[i].x_ready));
            chk("tbl_out_valid", 64'(io_out_valid), 64'(tbl[i].x_ovalid));
            chk("tbl_rd_block", 64'(io_rd_block), 64'(tbl[i].x_block));
            if (tbl[i].x_ovalid) chk("tbl_out_idx", 64'(io_out_idx), 64'(tbl[i].x_idx));
            advance();
        end

        // All requesters streaming: grants rotate 0..7,0 and each entry surfaces one cycle later.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive_eval('1, 1'b0, 1'b1);
            chk("rr_order", 64'(io_in_ready), 64'(8'h01 << (c % 8)));
            if (c > 0) chk("idx_follow", 64'(io_out_idx), 64'(((c - 1) % 8) * 5 + 3));
            model_compare();
            advance();
        end

        // One entry queued behind a continuously busy read port.
        do_reset();
        drive_eval(8'h01, 1'b1, 1'b1);
        model_compare();
        advance();
        for (int c = 1; c <= 16; c++) begin
            drive_eval('0, 1'b1, 1'b1);
            chk("starve_wait_valid", 64'(io_out_valid), 64'(0));
            model_compare();
            advance();
        end
        drive_eval('0, 1'b1, 1'b0);
        chk("force_valid", 64'(io_out_valid), 64'(1));
        chk("force_block", 64'(io_rd_block), 64'(1));
        chk("force_starved", 64'(io_starved), 64'(1));
        advance();
        drive_eval('0, 1'b1, 1'b0);
        chk("force_hold_block", 64'(io_rd_block), 64'(1));
        chk("force_pulse_once", 64'(io_starved), 64'(0));
        model_compare();
        advance();
        drive_eval('0, 1'b1, 1'b1);
        model_compare();
        advance();
        drive_eval('0, 1'b1, 1'b1);
        chk("post_force_block", 64'(io_rd_block), 64'(0));
        chk("post_force_valid", 64'(io_out_valid), 64'(0));
        advance();

        // Alternating read activity keeps resetting the starvation count.
        do_reset();
        drive_eval(8'h01, 1'b0, 1'b0);
        advance();
        for (int c = 0; c < 40; c++) begin
            drive_eval('0, (c % 2 == 0), 1'b0);
            chk("toggle_no_force", 64'(io_rd_block), 64'(0));
            model_compare();
            advance();
        end

        // Reset asserted between edges while full and forcing.
        do_reset();
        drive_eval(8'h01, 1'b1, 1'b0);
        advance();
        drive_eval(8'h02, 1'b1, 1'b0);
        advance();
        for (int c = 0; c < 20 && !m_force; c++) begin
            drive_eval('0, 1'b1, 1'b0);
            model_compare();
            advance();
        end
        drive_eval('1, 1'b1, 1'b0);
        chk("pre_reset_block", 64'(io_rd_block), 64'(1));
        chk("pre_reset_valid", 64'(io_out_valid), 64'(1));
        reset = 1'b1;
        #1;
        chk("async_valid", 64'(io_out_valid), 64'(0));
        chk("async_block", 64'(io_rd_block), 64'(0));
        chk("async_in_ready", 64'(io_in_ready), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        drive_eval('1, 1'b0, 1'b0);
        chk("post_reset_grant", 64'(io_in_ready), 64'(8'h01));
        model_compare();
        advance();

        // Randomized traffic with phases of heavy read activity to provoke starvation.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int busy_pct;
            logic [N-1:0] v;
            busy_pct = ((cyc / 250) % 2 == 1) ? 97 : 50;
            set_rand_data();
            v = N'($urandom);
            if ($urandom_range(0, 1) == 0) v = v & N'($urandom);
            drive_eval(v, ($urandom_range(0, 99) < busy_pct), ($urandom_range(0, 3) != 0));
            model_compare();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/meta_write_scheduler.md
Name: meta_write_scheduler

Overview:
Schedules cache-metadata write requests (idx, way_en, tag) from N requesters into the single-ported tag array. Replaces fixed-priority selection with round-robin arbitration and buffers granted writes in a small FIFO. The FIFO drains only when the array read port is idle. A starvation guard forces a write through after a bounded number of read-blocked cycles.

Parameters:
N_REQ, 8, number of requesters (>=2)
IDX_W, 6, set index width
WAY_W, 8, one-hot way enable width
TAG_W, 20, tag width
QDEPTH, 2, write FIFO entries (>=1)
STARVE_LIMIT, 16, consecutive read-blocked cycles with non-empty FIFO before a forced write (>=1)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high
io_in_valid  in  N_REQ  per-requester write valid
io_in_ready  out  N_REQ  per-requester accept
io_in_idx  in  N_REQ*IDX_W  packed; requester i at [i*IDX_W +: IDX_W]
io_in_way_en  in  N_REQ*WAY_W  packed, same layout
io_in_tag  in  N_REQ*TAG_W  packed, same layout
io_rd_busy  in  1  tag-array read port claimed this cycle
io_rd_block  out  1  asks readers to hold off (forced write in progress)
io_out_valid  out  1  write to tag array valid
io_out_ready  in  1  tag array accepts write
io_out_idx  out  IDX_W  head entry idx
io_out_way_en  out  WAY_W  head entry way_en
io_out_tag  out  TAG_W  head entry tag
io_starved  out  1  pulse: one cycle on each entry to FORCE

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous, active-high (reset).
- Reset values:
  - rr_ptr = N_REQ-1, so requester 0 has first priority.
  - FIFO count = 0; state = IDLE; starve counter = 0.
  - io_out_valid, io_rd_block, io_starved = 0.
  - io_in_ready = all 0 while reset is asserted.
- Arbitration (combinational):
  - Grant goes to the first valid requester in circular order rr_ptr+1, rr_ptr+2, ..., rr_ptr (mod N_REQ).
  - At most one grant per cycle.
  - io_in_ready[i] = grant[i] & can_enq.
  - can_enq = (count < QDEPTH) | deq_fire.
  - Full FIFO with a simultaneous dequeue still accepts one request.
- Enqueue fires on io_in_valid[g] & io_in_ready[g]; the entry appears at the FIFO tail next cycle. Set rr_ptr <= g only on enqueue.
- Latency: zero-wait path is 1 cycle (accept in cycle t, io_out_valid in t+1 if not blocked). No combinational path from io_in_* to io_out_*.
- Output:
  - io_out_* always shows the FIFO head.
  - io_out_valid = (count != 0) & (~io_rd_busy | state == FORCE).
  - deq_fire = io_out_valid & io_out_ready.
  - Entries drain in order. Count updates by +1, -1 or 0 (enqueue and dequeue in the same cycle).
- Starvation FSM, two states:
  - IDLE: starve counter increments when count != 0 & io_rd_busy & ~deq_fire; otherwise it clears to 0.
  - IDLE -> FORCE: when the counter is STARVE_LIMIT-1 and it would increment. Counter clears on the transition. io_starved pulses high for the first FORCE cycle.
  - FORCE: io_rd_block = 1 and io_out_valid ignores io_rd_busy.
  - FORCE -> IDLE: on deq_fire. Exactly one entry is forced per starvation event.
  - FORCE with io_out_ready low holds FORCE indefinitely.
- Boundaries:
  - Empty FIFO: io_out_valid = 0 and the counter holds 0.
  - Full FIFO with no dequeue: all io_in_ready = 0 and rr_ptr is unchanged.
  - rr_ptr wraps from N_REQ-1 to 0.
  - A requester holding valid without being granted keeps its data stable (upstream contract, not checked).
  - Reset asserted mid-operation discards all FIFO contents and returns to reset values immediately; no partial write is issued.
  - Wrong-width or non-one-hot way_en is passed through unchanged.

Test Plan:
- All 8 requesters valid continuously, io_out_ready=1, io_rd_busy=0:
  - Grants follow order 0,1,...,7,0.
  - io_out_idx equals each requester's idx one cycle after its accept.
- Requesters 2 and 5 valid, rr_ptr=2 -> grant 5; next cycle grant 2 (round-robin, not fixed priority).
- io_out_ready=0 with QDEPTH=2 and requester 0 streaming:
  - Two accepts, then io_in_ready[0]=0.
  - Raise io_out_ready -> same-cycle dequeue plus enqueue; count stays 2.
- One entry queued, io_rd_busy held 1, STARVE_LIMIT=16:
  - io_out_valid=0 for 16 cycles.
  - Cycle 17: io_out_valid=1, io_rd_block=1, io_starved pulses once.
  - After the dequeue, io_rd_block=0.
- io_rd_busy toggling 1,0 every cycle with the FIFO non-empty -> counter never exceeds 1; FORCE is never entered.
- Assert reset with 2 entries queued and in FORCE:
  - io_out_valid, io_rd_block and io_in_ready drop immediately, asynchronously, without waiting for a clock edge.
  - After release, the first grant goes to requester 0.
